fb_writer: RTL and testbench

Command-driven write engine sitting directly upstream of the framebuffer on its write port (`waddr`/`din`/`we`). It accepts pixel, horizontal-line and full-screen-fill commands over a valid/ready handshake. It converts each command into a sequence of single-cycle framebuffer writes, one per clock. This gives the CPU side a way to change display content while `LED_Controller` scans the read ports.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/fb_writer.sv | 176 +++++++++++++++++
 tb/tb_fb_writer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
//   Shared framebuffer definitions used by the write engine, the framebuffer
//   itself and the LED readout addressing.
//   - fb_op_t            : write-engine command opcodes
//   - fb_writer_state_t  : write-engine FSM states
//   - FB_* constants     : panel geometry and address width
//   - fb_addr(x, y)      : linear framebuffer address {y, x}
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_WIDTH  = 64;
   localparam int FB_HEIGHT = 64;
   localparam int FB_X_W    = 6;
   localparam int FB_Y_W    = 6;
   localparam int FB_ADDR_W = 12;

   typedef enum logic [1:0] {
      PIXEL = 2'd0,
      HLINE = 2'd1,
      FILL  = 2'd2,
      RSVD  = 2'd3
   } fb_op_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fb_writer_state_t;

   // Row-major packing; y[5] lands on the address MSB, which is the panel-half
   // select used by the readout ({half, row, col}).
   function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_X_W-1:0] x,
                                                    input logic [FB_Y_W-1:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/fb_writer.sv
// -----------------------------------------------------------------------------
// fb_writer
//   Command-driven framebuffer write engine. Turns PIXEL / HLINE / FILL
//   commands into back-to-back single-cycle writes on the framebuffer
//   write port.
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous active-low reset
//   cmd_valid  command present          cmd_ready  engine idle, can accept
//   cmd_op     0=PIXEL 1=HLINE 2=FILL 3=reserved (no-op)
//   cmd_x/y    start column / row       cmd_len    HLINE length 0..64
//   cmd_color  pixel value
//   fb_we / fb_waddr / fb_din   registered framebuffer write port
//   busy       a command is executing
// -----------------------------------------------------------------------------
module fb_writer
   import fb_pkg::*;
#(
   parameter int WIDTH   = FB_WIDTH,
   parameter int HEIGHT  = FB_HEIGHT,
   parameter int COLOR_W = 4,
   parameter int ADDR_W  = FB_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [FB_X_W-1:0]   cmd_x,
   input  logic [FB_Y_W-1:0]   cmd_y,
   input  logic [FB_X_W:0]     cmd_len,
   input  logic [COLOR_W-1:0]  cmd_color,
   output logic                fb_we,
   output logic [ADDR_W-1:0]   fb_waddr,
   output logic [COLOR_W-1:0]  fb_din,
   output logic                busy
);

   // One extra bit on both counters so the terminal values (WIDTH and
   // WIDTH*HEIGHT) are representable without wrapping.
   localparam int COL_W = FB_X_W + 1;
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [COL_W-1:0] ROW_END   = COL_W'(WIDTH);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIDTH * HEIGHT);

   fb_writer_state_t      state_q, state_d;
   logic                  fill_q, fill_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [COL_W-1:0]      col_end_q, col_end_d;
   logic [FB_Y_W-1:0]     row_q, row_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  fb_we_q, fb_we_d;
   logic [ADDR_W-1:0]     fb_waddr_q, fb_waddr_d;
   logic [COLOR_W-1:0]    fb_din_q, fb_din_d;
   logic                  busy_q, busy_d;

   fb_op_t                op_in;
   logic [COL_W-1:0]      room;
   logic [COL_W-1:0]      run_len;
   logic                  accept;

   assign op_in     = fb_op_t'(cmd_op);
   assign cmd_ready = (state_q == IDLE) && rst;
   assign accept    = cmd_valid && cmd_ready;

   // Pixels left on the row from cmd_x; HLINE is clipped to this so it never
   // spills into the next row. PIXEL is simply a one-pixel run.
   assign room    = ROW_END - {1'b0, cmd_x};
   assign run_len = (op_in == PIXEL) ? COL_W'(1)
                  : ((cmd_len < room) ? cmd_len : room);

   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      col_d      = col_q;
      col_end_d  = col_end_q;
      row_d      = row_q;
      cnt_d      = cnt_q;
      fb_we_d    = 1'b0;
      fb_waddr_d = fb_waddr_q;
      fb_din_d   = fb_din_q;
      busy_d     = busy_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op_in)
                  PIXEL, HLINE: begin
                     // Zero-length runs are consumed without leaving IDLE.
                     if (run_len != '0) begin
                        state_d    = RUN;
                        busy_d     = 1'b1;
                        fill_d     = 1'b0;
                        fb_we_d    = 1'b1;
                        fb_waddr_d = fb_addr(cmd_x, cmd_y);
                        fb_din_d   = cmd_color;
                        row_d      = cmd_y;
                        col_d      = {1'b0, cmd_x} + COL_W'(1);
                        col_end_d  = {1'b0, cmd_x} + run_len;
                     end
                  end
                  FILL: begin
                     state_d    = RUN;
                     busy_d     = 1'b1;
                     fill_d     = 1'b1;
                     fb_we_d    = 1'b1;
                     fb_waddr_d = '0;
                     fb_din_d   = cmd_color;
                     cnt_d      = CNT_W'(1);
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            // The first write was issued on the accept edge, so the counters
            // here always point at the next write to issue.
            if (fill_q) begin
               if (cnt_q == FILL_LAST) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  fb_we_d    = 1'b1;
                  fb_waddr_d = cnt_q[ADDR_W-1:0];
                  cnt_d      = cnt_q + CNT_W'(1);
               end
            end else begin
               if (col_q == col_end_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  fb_we_d    = 1'b1;
                  fb_waddr_d = fb_addr(col_q[FB_X_W-1:0], row_q);
                  col_d      = col_q + COL_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fill_q     <= 1'b0;
         col_q      <= '0;
         col_end_q  <= '0;
         row_q      <= '0;
         cnt_q      <= '0;
         fb_we_q    <= 1'b0;
         fb_waddr_q <= '0;
         fb_din_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         col_q      <= col_d;
         col_end_q  <= col_end_d;
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         fb_we_q    <= fb_we_d;
         fb_waddr_q <= fb_waddr_d;
         fb_din_q   <= fb_din_d;
         busy_q     <= busy_d;
      end
   end

   assign fb_we    = fb_we_q;
   assign fb_waddr = fb_waddr_q;
   assign fb_din   = fb_din_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_fb_writer.sv
// -----------------------------------------------------------------------------
// tb_fb_writer
//   Directed bench for fb_writer. Each accepted command expands into a list of
//   expected (address, data) writes; the checker pops one entry per write
//   cycle and requires fb_we/busy low and cmd_ready high when nothing is due.
// -----------------------------------------------------------------------------
module tb_fb_writer;

   typedef struct packed {
      logic [11:0] addr;
      logic [3:0]  din;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [5:0]  cmd_x = 6'd0;
   logic [5:0]  cmd_y = 6'd0;
   logic [6:0]  cmd_len = 7'd0;
   logic [3:0]  cmd_color = 4'd0;
   logic        fb_we;
   logic [11:0] fb_waddr;
   logic [3:0]  fb_din;
   logic        busy;

   fb_writer dut (
      .clk       (clk),
      .rst       (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_x     (cmd_x),
      .cmd_y     (cmd_y),
      .cmd_len   (cmd_len),
      .cmd_color (cmd_color),
      .fb_we     (fb_we),
      .fb_waddr  (fb_waddr),
      .fb_din    (fb_din),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   wr_t exp_q[$];
   wr_t obs_q[$];
   int  total = 0;
   int  bad = 0;
   int  cycle = 0;
   int  fail_prints = 0;
   bit  model_ready = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   // Per-cycle checker, sampled mid-cycle.
   always @(negedge clk) begin
      wr_t e;
      bit  exp_we;
      if (fb_we === 1'b1) obs_q.push_back({fb_waddr, fb_din});
      total++;
      if (!rst_n) begin
         model_ready = 1'b0;
         if (fb_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 ||
             fb_waddr !== 12'd0 || fb_din !== 4'd0) begin
            bad++;
            if (fail_prints < 30)
               $display("FAIL reset_state cycle=%0d got we=%b busy=%b rdy=%b addr=%0d din=%h want all 0",
                        cycle, fb_we, busy, cmd_ready, fb_waddr, fb_din);
            fail_prints++;
         end
      end else begin
         exp_we = (exp_q.size() != 0);
         e = exp_we ? exp_q.pop_front() : '0;
         model_ready = !exp_we;
         if (fb_we !== exp_we || busy !== exp_we || cmd_ready !== !exp_we ||
             (exp_we && (fb_waddr !== e.addr || fb_din !== e.din))) begin
            bad++;
            if (fail_prints < 30)
               $display("FAIL cycle_check cycle=%0d got we=%b busy=%b rdy=%b addr=%0d din=%h want we=%b busy=%b rdy=%b addr=%0d din=%h",
                        cycle, fb_we, busy, cmd_ready, fb_waddr, fb_din,
                        exp_we, exp_we, !exp_we, e.addr, e.din);
            fail_prints++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   function automatic int obs_addr(input int i);
      return (i < obs_q.size()) ? int'(obs_q[i].addr) : -1;
   endfunction

   function automatic int obs_din(input int i);
      return (i < obs_q.size()) ? int'(obs_q[i].din) : -1;
   endfunction

   // Presents a command, waits for the handshake and queues its writes.
   // Fields are scrambled right after the accept edge.
   task automatic send_cmd(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                           input logic [6:0] len, input logic [3:0] col, output int acc_cycle);
      wr_t w[$];
      int  n;
      bit  ok = 1'b0;
      case (op)
         2'd0: w.push_back({12'(int'(y) * 64 + int'(x)), col});
         2'd1: begin
            n = (int'(len) < 64 - int'(x)) ? int'(len) : 64 - int'(x);
            for (int i = 0; i < n; i++) w.push_back({12'(int'(y) * 64 + int'(x) + i), col});
         end
         2'd2: for (int a = 0; a < 4096; a++) w.push_back({12'(a), col});
         default: ;
      endcase
      @(negedge clk);
      #1;
      cmd_op = op; cmd_x = x; cmd_y = y; cmd_len = len; cmd_color = col;
      cmd_valid = 1'b1;
      for (int k = 0; k < 6000; k++) begin
         @(posedge clk);
         if (model_ready) begin
            ok = 1'b1;
            break;
         end
      end
      acc_cycle = cycle;
      if (ok) foreach (w[i]) exp_q.push_back(w[i]);
      #1;
      cmd_valid = 1'b0;
      cmd_x = cmd_x ^ 6'h2A; cmd_y = cmd_y ^ 6'h15; cmd_color = ~cmd_color;
      cmd_op = 2'd2; cmd_len = 7'd64;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no accept want accept op=%0d", op);
      end else begin
         $display("cmd op=%0d x=%0d y=%0d len=%0d color=%h accepted cycle=%0d writes=%0d",
                  op, x, y, len, col, acc_cycle, w.size());
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 6000 && exp_q.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("drain", exp_q.size(), 0);
      #1;
   endtask

   initial begin
      int a0, a1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // Single pixel in the lower half of the panel.
      obs_q.delete();
      send_cmd(2'd0, 6'd5, 6'd40, 7'd0, 4'hA, a0);
      wait_idle();
      chk("pixel_count", obs_q.size(), 1);
      chk("pixel_addr", obs_addr(0), 2565);
      chk("pixel_din", obs_din(0), 10);

      // HLINE clipped at the right edge.
      obs_q.delete();
      send_cmd(2'd1, 6'd60, 6'd0, 7'd10, 4'h7, a0);
      wait_idle();
      chk("hline_clip_count", obs_q.size(), 4);
      chk("hline_clip_first", obs_addr(0), 60);
      chk("hline_clip_last", obs_addr(3), 63);

      // Unclipped HLINE on the last row.
      obs_q.delete();
      send_cmd(2'd1, 6'd2, 6'd63, 7'd5, 4'hC, a0);
      wait_idle();
      chk("hline_count", obs_q.size(), 5);
      chk("hline_first", obs_addr(0), 4034);

      // Zero-write commands, back to back.
      obs_q.delete();
      send_cmd(2'd1, 6'd9, 6'd9, 7'd0, 4'h1, a0);
      send_cmd(2'd3, 6'd9, 6'd9, 7'd3, 4'h1, a1);
      wait_idle();
      chk("zero_write_count", obs_q.size(), 0);
      chk("zero_write_reaccept", a1 - a0, 1);

      // FILL with a PIXEL held pending behind it.
      obs_q.delete();
      send_cmd(2'd2, 6'd17, 6'd33, 7'd9, 4'h3, a0);
      send_cmd(2'd0, 6'd1, 6'd1, 7'd0, 4'hF, a1);
      wait_idle();
      chk("fill_pending_accept", a1 - a0, 4097);
      chk("fill_total_writes", obs_q.size(), 4097);
      chk("fill_last_addr", obs_addr(4095), 4095);
      chk("fill_din", obs_din(2000), 3);
      chk("pending_pixel_addr", obs_addr(4096), 65);

      // Reset in the middle of a FILL.
      obs_q.delete();
      send_cmd(2'd2, 6'd0, 6'd0, 7'd0, 4'h6, a0);
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_we", int'(fb_we), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_writes_before", obs_q.size(), 100);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk("rst_release_ready", int'(cmd_ready), 1);
      chk("rst_no_writes_after", obs_q.size(), 100);

      // Inputs change right after accept; captured values must be used.
      obs_q.delete();
      send_cmd(2'd0, 6'd7, 6'd3, 7'd0, 4'h5, a0);
      wait_idle();
      chk("capture_count", obs_q.size(), 1);
      chk("capture_addr", obs_addr(0), 199);
      chk("capture_din", obs_din(0), 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
